// File: rtl/dft_mac_sequencer.sv
// ============================================================================
// dft_mac_sequencer
// ----------------------------------------------------------------------------
// Controller for a direct-DFT multiply-accumulate datapath. For every output
// bin k = 0..N-1 it sweeps the sample addresses n = 0..N-1 and issues the
// twiddle index (k*n) mod N. The product reaches the accumulator PIPE_LAT
// cycles after the read strobe, so the accumulator enable and clear are
// delayed copies of the read strobe. Each finished bin is handed to the
// write side with a valid/ready handshake. After the last bin is accepted,
// a one-cycle calculation-end pulse is produced.
//
// Parameters:
//   ADDR_W    width of sample address, twiddle index, bin index and N
//   PIPE_LAT  cycles from o_rd_en to the product at the accumulator (1..7)
//
// Ports:
//   clk            system clock, rising edge
//   nrst           asynchronous active-low reset
//   i_start        start request, only looked at while idle
//   i_samp_number  transform length N, captured on an accepted start
//   i_data_loaded  sample RAM holds all N samples
//   o_busy         high in every state except idle
//   o_rd_adr       sample address n
//   o_rd_en        sample read strobe
//   o_tw_idx       twiddle ROM index, aligned with o_rd_adr
//   o_acc_ce       accumulator enable (o_rd_en delayed PIPE_LAT cycles)
//   o_acc_clr      first enable of a bin: accumulator loads instead of adds
//   o_bin_valid    accumulator holds a complete bin
//   o_bin_idx      index k of the presented bin
//   i_bin_ready    write side accepts the bin
//   o_calc_end     one-cycle pulse after the last bin is accepted
// ============================================================================
module dft_mac_sequencer #(
   parameter int ADDR_W   = 12,
   parameter int PIPE_LAT = 2
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_samp_number,
   input  logic              i_data_loaded,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_rd_adr,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_tw_idx,
   output logic              o_acc_ce,
   output logic              o_acc_clr,
   output logic              o_bin_valid,
   output logic [ADDR_W-1:0] o_bin_idx,
   input  logic              i_bin_ready,
   output logic              o_calc_end
);

   localparam int CNT_W = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_LOAD,
      S_RUN,
      S_DRAIN,
      S_EMIT,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic [ADDR_W-1:0] len, len_nx;
   logic [ADDR_W-1:0] k, k_nx;
   logic [ADDR_W-1:0] n, n_nx;
   logic [ADDR_W-1:0] tw, tw_nx;
   logic [CNT_W-1:0]  drain_cnt, drain_cnt_nx;

   logic [ADDR_W:0]   tw_sum;
   logic [ADDR_W-1:0] tw_wrap;
   logic              last_addr;
   logic              last_bin;

   logic              rd_en;
   logic              busy;
   logic              bin_valid;
   logic              calc_end;
   logic [PIPE_LAT-1:0] ce_pipe;
   logic [PIPE_LAT-1:0] clr_pipe;

   // Incremental twiddle index: (k*n) mod N is built by adding k once per
   // address. Both operands are below N, so the sum is below 2N and a single
   // conditional subtraction keeps it in range. The extra sum bit keeps the
   // carry so the compare against N is exact.
   always_comb begin
      tw_sum  = {1'b0, tw} + {1'b0, k};
      tw_wrap = ADDR_W'(tw_sum);
      if (tw_sum >= {1'b0, len}) begin
         tw_wrap = ADDR_W'(tw_sum - {1'b0, len});
      end
   end

   // Sweep-end flags. N is at least 2 whenever these are used, so N-1
   // cannot wrap.
   always_comb begin
      last_addr = (n == (len - ADDR_W'(1)));
      last_bin  = (k == (len - ADDR_W'(1)));
   end

   // Next-state and next-counter logic. Every register holds its value
   // unless the current state explicitly moves it.
   always_comb begin
      state_nx     = state;
      len_nx       = len;
      k_nx         = k;
      n_nx         = n;
      tw_nx        = tw;
      drain_cnt_nx = drain_cnt;

      case (state)
         S_IDLE: begin
            if (i_start) begin
               len_nx = i_samp_number;
               k_nx   = '0;
               n_nx   = '0;
               tw_nx  = '0;
               // A transform shorter than two points has no bins to sweep,
               // so it finishes immediately.
               if (i_samp_number < ADDR_W'(2)) begin
                  state_nx = S_DONE;
               end else begin
                  state_nx = S_WAIT_LOAD;
               end
            end
         end

         S_WAIT_LOAD: begin
            if (i_data_loaded) begin
               state_nx = S_RUN;
            end
         end

         S_RUN: begin
            if (last_addr) begin
               state_nx     = S_DRAIN;
               drain_cnt_nx = '0;
            end else begin
               n_nx  = n + ADDR_W'(1);
               tw_nx = tw_wrap;
            end
         end

         // Wait for the last product of the bin to leave the pipeline.
         S_DRAIN: begin
            if (drain_cnt == CNT_W'(PIPE_LAT - 1)) begin
               state_nx = S_EMIT;
            end else begin
               drain_cnt_nx = drain_cnt + CNT_W'(1);
            end
         end

         S_EMIT: begin
            if (i_bin_ready) begin
               if (last_bin) begin
                  state_nx = S_DONE;
               end else begin
                  k_nx     = k + ADDR_W'(1);
                  n_nx     = '0;
                  tw_nx    = '0;
                  state_nx = S_RUN;
               end
            end
         end

         S_DONE: begin
            state_nx = S_IDLE;
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // State, counters and output flags. The flags are registered from the
   // next state so each one is high during exactly the cycles the machine
   // sits in the matching state, without decoding glitches on the outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= S_IDLE;
         len       <= '0;
         k         <= '0;
         n         <= '0;
         tw        <= '0;
         drain_cnt <= '0;
         rd_en     <= 1'b0;
         busy      <= 1'b0;
         bin_valid <= 1'b0;
         calc_end  <= 1'b0;
      end else begin
         state     <= state_nx;
         len       <= len_nx;
         k         <= k_nx;
         n         <= n_nx;
         tw        <= tw_nx;
         drain_cnt <= drain_cnt_nx;
         rd_en     <= (state_nx == S_RUN);
         busy      <= (state_nx != S_IDLE);
         bin_valid <= (state_nx == S_EMIT);
         calc_end  <= (state_nx == S_DONE);
      end
   end

   // Accumulator control delay line. The clear tag travels with the read
   // of address 0 so it lands on the first enable of each bin.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ce_pipe  <= '0;
         clr_pipe <= '0;
      end else begin
         ce_pipe  <= (ce_pipe << 1) | PIPE_LAT'(rd_en);
         clr_pipe <= (clr_pipe << 1) | PIPE_LAT'(rd_en && (n == '0));
      end
   end

   assign o_busy      = busy;
   assign o_rd_adr    = n;
   assign o_rd_en     = rd_en;
   assign o_tw_idx    = tw;
   assign o_acc_ce    = ce_pipe[PIPE_LAT-1];
   assign o_acc_clr   = clr_pipe[PIPE_LAT-1];
   assign o_bin_valid = bin_valid;
   assign o_bin_idx   = k;
   assign o_calc_end  = calc_end;

endmodule

// File: tb/tb_dft_mac_sequencer.sv
// ============================================================================
// tb_dft_mac_sequencer
// ----------------------------------------------------------------------------
// Directed bench for dft_mac_sequencer (ADDR_W=12, PIPE_LAT=2). A small phase
// model (run / drain / emit / done) predicts every cycle of a transform; the
// twiddle indices for N=4 come from a hand-written table.
// ============================================================================
module tb_dft_mac_sequencer;

   localparam int ADDR_W   = 12;
   localparam int PIPE_LAT = 2;

   logic              clk;
   logic              nrst;
   logic              i_start;
   logic [ADDR_W-1:0] i_samp_number;
   logic              i_data_loaded;
   logic              o_busy;
   logic [ADDR_W-1:0] o_rd_adr;
   logic              o_rd_en;
   logic [ADDR_W-1:0] o_tw_idx;
   logic              o_acc_ce;
   logic              o_acc_clr;
   logic              o_bin_valid;
   logic [ADDR_W-1:0] o_bin_idx;
   logic              i_bin_ready;
   logic              o_calc_end;

   logic [41:0] out_vec;

   int checks;
   int errors;

   // Hand-computed (k*n) mod 4, rows are bins, columns are addresses.
   int tw_table [4][4] = '{'{0, 0, 0, 0},
                           '{0, 1, 2, 3},
                           '{0, 2, 0, 2},
                           '{0, 3, 2, 1}};

   dft_mac_sequencer #(
      .ADDR_W  (ADDR_W),
      .PIPE_LAT(PIPE_LAT)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .i_start      (i_start),
      .i_samp_number(i_samp_number),
      .i_data_loaded(i_data_loaded),
      .o_busy       (o_busy),
      .o_rd_adr     (o_rd_adr),
      .o_rd_en      (o_rd_en),
      .o_tw_idx     (o_tw_idx),
      .o_acc_ce     (o_acc_ce),
      .o_acc_clr    (o_acc_clr),
      .o_bin_valid  (o_bin_valid),
      .o_bin_idx    (o_bin_idx),
      .i_bin_ready  (i_bin_ready),
      .o_calc_end   (o_calc_end)
   );

   // Every output packed together so reset can be checked in one compare.
   assign out_vec = {o_busy, o_rd_en, o_acc_ce, o_acc_clr, o_bin_valid, o_calc_end,
                     o_rd_adr, o_tw_idx, o_bin_idx};

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // Pulses start for one cycle with the given length and load flag.
   // Returns at the falling edge of the first cycle after the start is taken.
   task automatic applyStimulus(input logic [ADDR_W-1:0] len, input logic loaded);
      @(negedge clk);
      i_samp_number = len;
      i_data_loaded = loaded;
      i_bin_ready   = 1'b1;
      i_start       = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   // Follows one whole transform from its first RUN cycle to o_calc_end,
   // predicting each cycle with a phase model. 'stall' holds ready low for
   // that many cycles on bin 1; 'inject' fires a second start mid-run.
   task automatic runAndCheck(input int len, input int stall, input bit inject);
      int  phase;
      int  cnt;
      int  bin_k;
      int  stall_cnt;
      int  exp_tw;
      bit  exp_rd;
      bit  cur_clr;
      bit  h1_en, h2_en, h1_clr, h2_clr;
      bit  finished;
      phase     = 0;
      cnt       = 0;
      bin_k     = 0;
      stall_cnt = 0;
      h1_en     = 1'b0;
      h2_en     = 1'b0;
      h1_clr    = 1'b0;
      h2_clr    = 1'b0;
      finished  = 1'b0;
      i_bin_ready = 1'b1;
      for (int iter = 0; iter < len * (len + 3) + stall + 4 && !finished; iter++) begin
         @(negedge clk);
         if (inject && iter == 3) begin
            i_start       = 1'b1;
            i_samp_number = ADDR_W'(4);
         end
         if (inject && iter == 4) begin
            i_start = 1'b0;
         end
         exp_rd  = (phase == 0);
         cur_clr = 1'b0;
         checkOutput("rd_en", o_rd_en, exp_rd);
         checkOutput("bin_valid", o_bin_valid, phase == 2);
         checkOutput("calc_end", o_calc_end, phase == 3);
         checkOutput("busy", o_busy, 1);
         checkOutput("acc_ce", o_acc_ce, h2_en);
         checkOutput("acc_clr", o_acc_clr, h2_clr);
         case (phase)
            0: begin
               if (len == 4) begin
                  exp_tw = tw_table[bin_k % 4][cnt % 4];
               end else begin
                  exp_tw = (bin_k * cnt) % len;
               end
               checkOutput("rd_adr", o_rd_adr, cnt);
               checkOutput("tw_idx", o_tw_idx, exp_tw);
               cur_clr = (cnt == 0);
               cnt++;
               if (cnt == len) begin
                  phase = 1;
                  cnt   = 0;
               end
            end
            1: begin
               cnt++;
               if (cnt == PIPE_LAT) begin
                  phase = 2;
               end
            end
            2: begin
               checkOutput("bin_idx", o_bin_idx, bin_k);
               if (stall > 0 && bin_k == 1 && stall_cnt < stall) begin
                  i_bin_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  i_bin_ready = 1'b1;
               end
               if (i_bin_ready) begin
                  bin_k++;
                  cnt = 0;
                  phase = (bin_k == len) ? 3 : 0;
               end
            end
            default: begin
               checkOutput("end_cycle", iter, len * (len + 3) + stall);
               finished = 1'b1;
            end
         endcase
         h2_en  = h1_en;
         h1_en  = exp_rd;
         h2_clr = h1_clr;
         h1_clr = cur_clr;
      end
      checkOutput("run_finished", finished, 1);
      @(negedge clk);
      checkOutput("end_pulse_once", o_calc_end, 0);
      checkOutput("idle_after_end", o_busy, 0);
   endtask

   // Main sequence of directed scenarios.
   initial begin
      bit found;
      checks        = 0;
      errors        = 0;
      nrst          = 1'b0;
      i_start       = 1'b0;
      i_samp_number = '0;
      i_data_loaded = 1'b0;
      i_bin_ready   = 1'b0;

      #12;
      checkOutput("reset_outputs", out_vec, 0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      checkOutput("idle_outputs", out_vec, 0);

      $display("[TB] N=4 nominal run");
      applyStimulus(ADDR_W'(4), 1'b1);
      runAndCheck(4, 0, 1'b0);

      $display("[TB] N=4 with 5-cycle backpressure on bin 1");
      applyStimulus(ADDR_W'(4), 1'b1);
      runAndCheck(4, 5, 1'b0);

      $display("[TB] N=4 with data loaded 10 cycles late");
      applyStimulus(ADDR_W'(4), 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("wait_load_rd_en", o_rd_en, 0);
         checkOutput("wait_load_busy", o_busy, 1);
      end
      i_data_loaded = 1'b1;
      runAndCheck(4, 0, 1'b0);

      $display("[TB] N=1 start");
      applyStimulus(ADDR_W'(1), 1'b1);
      checkOutput("n1_calc_end", o_calc_end, 1);
      checkOutput("n1_bin_valid", o_bin_valid, 0);
      checkOutput("n1_rd_en", o_rd_en, 0);
      @(negedge clk);
      checkOutput("n1_end_drop", o_calc_end, 0);
      checkOutput("n1_idle", o_busy, 0);
      checkOutput("n1_bin_valid_after", o_bin_valid, 0);

      $display("[TB] N=8 with a second start mid-run");
      applyStimulus(ADDR_W'(8), 1'b1);
      runAndCheck(8, 0, 1'b1);

      $display("[TB] reset in the middle of an N=8 run");
      applyStimulus(ADDR_W'(8), 1'b1);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (o_rd_en && o_rd_adr == ADDR_W'(3)) begin
            found = 1'b1;
         end
      end
      checkOutput("reach_mid_run", found, 1);
      #2;
      nrst = 1'b0;
      #1;
      checkOutput("async_clear", out_vec, 0);
      @(negedge clk);
      checkOutput("held_in_reset", out_vec, 0);
      nrst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("quiet_after_reset", out_vec, 0);
      end

      $display("[TB] N=4 rerun after reset");
      applyStimulus(ADDR_W'(4), 1'b1);
      runAndCheck(4, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dft_mac_sequencer.md
Name: dft_mac_sequencer

Overview:
- Controller for the direct-DFT multiply-accumulate datapath (sample RAM, cache read port, real/imag MUL_UNIT pair, rounding, Accumulation_unit).
- For each output bin k = 0..N-1, it sweeps sample addresses n = 0..N-1 and issues the twiddle index (k·n) mod N.
- It times the accumulator clock-enable and clear against the datapath pipeline latency.
- It hands each finished bin to the AXI write side with a valid/ready handshake, then signals calculation end.

Parameters:
- ADDR_W, 12, width of sample address, twiddle index, bin index and N.
- PIPE_LAT, 2, cycles from o_rd_en to the product being present at the accumulator input (RAM read + MUL/round); legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_samp_number  in  ADDR_W  transform length N; captured on accepted start.
- i_data_loaded  in  1  RAM holds all N samples (from AXI bridge).
- o_busy  out  1  high in every state except IDLE.
- o_rd_adr  out  ADDR_W  sample address n.
- o_rd_en  out  1  sample read strobe.
- o_tw_idx  out  ADDR_W  twiddle ROM index, aligned with o_rd_adr.
- o_acc_ce  out  1  accumulator enable; o_rd_en delayed PIPE_LAT cycles.
- o_acc_clr  out  1  high with the first o_acc_ce of a bin; accumulator loads instead of adding.
- o_bin_valid  out  1  accumulator holds a complete bin.
- o_bin_idx  out  ADDR_W  index k of the presented bin.
- i_bin_ready  in  1  write side accepts the bin.
- o_calc_end  out  1  one-cycle pulse after the last bin is accepted.

Behaviour:
- Reset (async, nrst=0):
  - State goes to IDLE.
  - All outputs are 0, including the delay line and the registered N, k, n and tw.
- Outputs: all outputs are registered.
- IDLE:
  - On i_start=1, capture N, set k=0, n=0, tw=0, and go to WAIT_LOAD.
  - If N<2, go directly to DONE instead; no bins are produced.
- WAIT_LOAD: wait for i_data_loaded=1, then go to RUN.
- RUN, one address per cycle:
  - o_rd_en=1, o_rd_adr=n, o_tw_idx=tw.
  - Next tw = tw+k, minus N if the sum is ≥ N. The sum is computed ADDR_W+1 bits wide. No multiplier.
  - On n=N-1, go to DRAIN with o_rd_en=0 the following cycle.
- DRAIN:
  - Hold for PIPE_LAT cycles so the last o_acc_ce issues.
  - Then go to EMIT with o_bin_valid=1 and o_bin_idx=k.
- EMIT:
  - o_bin_valid stays high and o_bin_idx stays stable until i_bin_ready=1 (transfer on valid&&ready).
  - On transfer, if k=N-1, go to DONE.
  - Otherwise set k=k+1, n=0, tw=0 and go to RUN the next cycle.
  - o_bin_valid drops the cycle after transfer.
- DONE: pulse o_calc_end for one cycle, then return to IDLE.
- Accumulator control:
  - o_acc_ce is a PIPE_LAT-deep shift of o_rd_en.
  - o_acc_clr is a PIPE_LAT-deep shift of (o_rd_en && n==0).
- Timing and start handling:
  - Per-bin cycles with ready held high: N + PIPE_LAT + 1.
  - i_start while busy is ignored. i_samp_number changes while busy have no effect.
- Reset mid-operation: everything clears immediately. No partial bin is presented and o_calc_end does not fire.

Test Plan:
- N=4, PIPE_LAT=2, i_data_loaded=1, ready tied 1:
  - o_tw_idx per bin: k0 0,0,0,0; k1 0,1,2,3; k2 0,2,0,2; k3 0,3,2,1.
  - o_rd_adr 0..3 for every bin.
  - o_calc_end 28 cycles after the first RUN cycle.
- Same run, alignment checks:
  - o_acc_ce rises exactly 2 cycles after each o_rd_en rise.
  - o_acc_clr is coincident with the first o_acc_ce of every bin.
  - o_bin_idx sequence is 0,1,2,3.
- Backpressure: hold i_bin_ready=0 for 5 cycles on bin 1 → o_bin_valid and o_bin_idx=1 stay stable, no new o_rd_en, total run +5 cycles.
- i_data_loaded held 0 for 10 cycles after start → no o_rd_en; RUN starts the cycle after it rises.
- N=1 start → o_calc_end one cycle later, o_bin_valid never asserted, back to IDLE. A second i_start during a N=8 run is ignored.
- Assert nrst=0 mid-RUN of N=8 → all outputs 0 asynchronously. A fresh start with N=4 then reproduces the first scenario exactly.
